ling_multiword_sub: RTL and testbench
=====================================

Name: ling_multiword_sub

Overview:
- Streaming multi-limb subtractor, D = A - B, operands up to LIMBS x 16 bits.
- Built around a 16-bit sparse-4 Ling carry core, extended with a carry-in and a carry-out.
- Accepts one 16-bit limb pair per cycle, least-significant limb first; carry/borrow is held in a register between limbs.
- Sits after the 16-bit Ling adder family as its inverse-direction companion. Output is a registered limb stream with valid/ready handshake.

Parameters:
LIMBS, 4, maximum limbs per operand (>=1); default gives 64-bit operands.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  limb pair on a_limb/b_limb valid.
in_ready  output  1  block can accept a limb this cycle.
a_limb  input  16  minuend limb.
b_limb  input  16  subtrahend limb.
in_last  input  1  current limb is the operand's most-significant limb.
out_valid  output  1  diff_limb valid.
out_ready  input  1  downstream accepts diff_limb.
diff_limb  output  16  difference limb.
out_last  output  1  diff_limb is the final limb of the operand.
borrow_out  output  1  final borrow (A<B unsigned); valid only with out_last, 0 otherwise.
len_err  output  1  sticky: in_last disagreed with the LIMBS count.

Behaviour:
- Core arithmetic: diff = a_limb + ~b_limb + c, using the Ling core with c as carry-in. c_next is the core's carry-out.
- c is 1 at operand start. After every accepted limb, c takes the carry-out. After a terminating limb, c returns to 1.
- Handshake: a limb is accepted when in_valid && in_ready.
- in_ready = !rst && (!out_valid || out_ready).
- Output: single-entry register. An accepted limb appears on diff_limb/out_last/borrow_out with out_valid=1 on the next cycle, so latency is 1 cycle.
- Throughput is 1 limb/cycle while out_ready=1.
- out_valid drops when the entry is consumed and no new limb is accepted in the same cycle.
- Output fields are held stable while out_valid && !out_ready.
- Limb counter cnt runs 0..LIMBS-1 and increments per accepted limb.
- A limb is terminating when in_last=1 or cnt==LIMBS-1, whichever comes first. On a terminating limb: out_last=1, borrow_out=!carry_out, cnt returns to 0.
- len_err is set when a terminating limb has in_last != (cnt==LIMBS-1). It stays set until rst.
- State machine:
  - IDLE: cnt=0, c=1. A non-terminating accepted limb moves to RUN; a terminating one stays in IDLE.
  - RUN: the terminating accepted limb moves to IDLE.
- Simultaneous events:
  - Output consumed and new limb accepted in the same cycle: the register loads the new limb with no bubble.
  - in_valid without in_ready: no state change.
- Reset values: in_ready=0 during rst, out_valid=0, diff_limb=0, out_last=0, borrow_out=0, len_err=0, cnt=0, c=1, state IDLE.
- Reset mid-operand discards the partial operand and any buffered output.
- LIMBS=1: every limb is terminating. in_last=0 sets len_err.

Optional Feature:
Macro LING_SUB_ZERO_FLAG_EN.
- Defined: adds output port diff_zero (1 bit). On the out_last limb it is 1 iff every diff limb of that operand was 0x0000, i.e. A==B. It is 0 on non-last limbs and 0 at reset. A running AND register is cleared to 1 on operand start.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. LIMBS=4, A=0x0000_0000_0001_0000, B=0x0000_0000_0000_0001, out_ready=1 -> diff limbs 0xFFFF,0x0000,0x0000,0x0000; out_last on the 4th limb; borrow_out=0; each limb 1 cycle after acceptance.
2. A=0, B=1 (4 limbs) -> all limbs 0xFFFF, borrow_out=1 on the last limb; with LING_SUB_ZERO_FLAG_EN, diff_zero=0. Then A=B=0x1234_5678_9ABC_DEF0 -> all zero limbs, borrow_out=0, diff_zero=1.
3. Backpressure: stream two operands, hold out_ready=0 for 5 cycles mid-operand -> in_ready=0 during the stall, diff_limb/out_last stable, no limb lost or duplicated, results match case 1.
4. Short operand: in_last=1 on the 2nd limb, A limbs 0x0000,0x0005, B limbs 0x0001,0x0002 -> diff 0xFFFF,0x0002, out_last on the 2nd limb, len_err=1. The next operand starts with c=1 and gives the correct result.
5. Reset mid-operand: accept 2 limbs of A=0,B=1, assert rst 1 cycle -> outputs at reset values, in_ready=0 during rst. A following operand A=5,B=3 gives 0x0002,0,0,0 with borrow_out=0.
6. Random: 2000 operands, random in_valid/out_ready gaps -> every limb and borrow_out match the behavioural model ((A-B) mod 2^64, A<B).

Source files
------------

// File: rtl/ling_multiword_sub.sv
// Streaming multi-limb subtractor D = A - B, one 16-bit limb per cycle, LSB limb first, built on a sparse-4 Ling carry core.
// Optional diff_zero (A==B) output is enabled by defining LING_SUB_ZERO_FLAG_EN.

module ling_core16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] t;
  logic [16:0] tp;
  logic [16:0] h;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic [4:0]  hb;

  // Ling pseudo-carry h[i+1] = g[i] | t[i-1] & h[i]; real carry c[i] = t[i-1] & h[i]; cin sits at h[0] with t[-1] = 1
  always_comb begin
    g  = a & b;
    t  = a | b;
    tp = {t, 1'b1};
    gg = '0;
    pp = '0;
    hb = '0;
    h  = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = 1'b0;
      pp[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (tp[4*k+j] & gg[k]);
        pp[k] = tp[4*k+j] & pp[k];
      end
    end
    hb[0] = cin;
    for (int k = 0; k < 4; k++) begin
      hb[k+1] = gg[k] | (pp[k] & hb[k]);
    end
    for (int k = 0; k < 4; k++) begin
      h[4*k] = hb[k];
      for (int j = 0; j < 3; j++) begin
        h[4*k+j+1] = g[4*k+j] | (tp[4*k+j] & h[4*k+j]);
      end
    end
    h[16] = hb[4];
    c     = tp & h;
    sum   = a ^ b ^ c[15:0];
    cout  = c[16];
  end

endmodule

module ling_multiword_sub #(
  parameter int LIMBS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_limb,
  input  logic [15:0] b_limb,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff_limb,
  output logic        out_last,
  output logic        borrow_out,
  output logic        len_err
`ifdef LING_SUB_ZERO_FLAG_EN
  ,
  output logic        diff_zero
`endif
);

  localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMBS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          c;
  logic          cin;
  logic [15:0]   sum;
  logic          cout;
  logic          accept;
  logic          at_max;
  logic          term;
  logic [15:0]   b_inv;

  always_comb begin
    in_ready = !rst && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    at_max   = (cnt == CNT_MAX);
    term     = in_last || at_max;
    cin      = (state == IDLE) ? 1'b1 : c;
    b_inv    = ~b_limb;
  end

  ling_core16 u_core (
    .a    (a_limb),
    .b    (b_inv),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

`ifdef LING_SUB_ZERO_FLAG_EN
  logic zero_acc;
  logic sum_zero;
  assign sum_zero = (sum == 16'h0000);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      c          <= 1'b1;
      out_valid  <= 1'b0;
      diff_limb  <= '0;
      out_last   <= 1'b0;
      borrow_out <= 1'b0;
      len_err    <= 1'b0;
`ifdef LING_SUB_ZERO_FLAG_EN
      diff_zero  <= 1'b0;
      zero_acc   <= 1'b1;
`endif
    end else if (accept) begin
      out_valid  <= 1'b1;
      diff_limb  <= sum;
      out_last   <= term;
      borrow_out <= term & ~cout;
      if (term) begin
        state <= IDLE;
        cnt   <= '0;
        c     <= 1'b1;
        if (in_last != at_max) len_err <= 1'b1;
      end else begin
        state <= RUN;
        cnt   <= cnt + CW'(1);
        c     <= cout;
      end
`ifdef LING_SUB_ZERO_FLAG_EN
      diff_zero <= term & zero_acc & sum_zero;
      zero_acc  <= term | (zero_acc & sum_zero);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ling_multiword_sub.sv
// Scoreboard bench for ling_multiword_sub: directed cases, backpressure, reset, then random operands.
// Define LING_SUB_ZERO_FLAG_EN to also check diff_zero.

module tb_ling_multiword_sub;

  localparam int LIMBS = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_limb;
  logic [15:0] b_limb;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff_limb;
  logic        out_last;
  logic        borrow_out;
  logic        len_err;
`ifdef LING_SUB_ZERO_FLAG_EN
  logic        diff_zero;
`endif

  ling_multiword_sub #(.LIMBS(LIMBS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_limb     (a_limb),
    .b_limb     (b_limb),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff_limb  (diff_limb),
    .out_last   (out_last),
    .borrow_out (borrow_out),
    .len_err    (len_err)
`ifdef LING_SUB_ZERO_FLAG_EN
    ,
    .diff_zero  (diff_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } in_t;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
    logic        borrow;
    logic        zero;
    logic        err;
  } exp_t;

  in_t  inq[$];
  exp_t pend[$];
  exp_t sb[$];

  int          n_checks;
  int          n_fail;
  bit          exp_len_err;
  bit          prev_hold;
  bit          prev_acc;
  logic [15:0] prev_diff;
  logic        prev_last;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue one operand of n limbs; only the first 'keep' limbs are actually sent.
  task automatic load_operand(input logic [63:0] a, input logic [63:0] b, input int n,
                              input bit use_last, input int keep);
    logic [63:0] mask;
    logic [63:0] d;
    bit          brw;
    in_t         it;
    exp_t        e;
    mask = (n >= 4) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (16 * n)) - 64'd1);
    d    = (a - b) & mask;
    brw  = ((a & mask) < (b & mask));
    for (int i = 0; i < keep; i++) begin
      it.a     = a[16*i +: 16];
      it.b     = b[16*i +: 16];
      it.last  = use_last && (i == n - 1);
      e.d      = d[16*i +: 16];
      e.last   = (i == n - 1);
      e.borrow = (i == n - 1) && brw;
      e.zero   = (i == n - 1) && (d == 64'd0);
      e.err    = (i == n - 1) && ((use_last ? 1'b1 : 1'b0) != (i == LIMBS - 1));
      inq.push_back(it);
      pend.push_back(e);
    end
  endtask

  task automatic step(input bit pv, input bit pr);
    exp_t e;
    exp_t p;
    in_t  it;
    @(negedge clk);
    if (pv && inq.size() > 0) begin
      in_valid = 1'b1;
      a_limb   = inq[0].a;
      b_limb   = inq[0].b;
      in_last  = inq[0].last;
    end else begin
      in_valid = 1'b0;
      a_limb   = 16'($urandom);
      b_limb   = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
    end
    out_ready = pr;
    #1;
    check_val("len_err", len_err, exp_len_err);
    check_val("in_ready", in_ready, !out_valid || out_ready);
    if (prev_acc) check_val("latency_valid", out_valid, 1);
    if (prev_hold) begin
      check_val("hold_valid", out_valid, 1);
      check_val("hold_diff", diff_limb, prev_diff);
      check_val("hold_last", out_last, prev_last);
    end
    prev_hold = out_valid && !out_ready;
    prev_diff = diff_limb;
    prev_last = out_last;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check_val("diff_limb", diff_limb, e.d);
        check_val("out_last", out_last, e.last);
        check_val("borrow_out", borrow_out, e.borrow);
`ifdef LING_SUB_ZERO_FLAG_EN
        check_val("diff_zero", diff_zero, e.zero);
`endif
      end
    end
    prev_acc = in_valid && in_ready;
    if (in_valid && in_ready) begin
      it = inq.pop_front();
      p  = pend.pop_front();
      sb.push_back(p);
      if (p.err) exp_len_err = 1'b1;
    end
  endtask

  task automatic drain(input int vp, input int rp, input int stall_at, input int bound);
    int cyc;
    bit pv;
    bit pr;
    cyc = 0;
    while ((inq.size() > 0 || sb.size() > 0) && cyc < bound) begin
      pv = ($urandom_range(0, 99) < vp);
      pr = ($urandom_range(0, 99) < rp);
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) pr = 1'b0;
      step(pv, pr);
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5 && out_valid)
        check_val("stall_in_ready", in_ready, 0);
      cyc++;
    end
    check_val("drain_left", inq.size() + sb.size(), 0);
    inq.delete();
    pend.delete();
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_diff_limb", diff_limb, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_borrow_out", borrow_out, 0);
    check_val("rst_len_err", len_err, 0);
`ifdef LING_SUB_ZERO_FLAG_EN
    check_val("rst_diff_zero", diff_zero, 0);
`endif
    inq.delete();
    pend.delete();
    sb.delete();
    exp_len_err = 1'b0;
    prev_hold   = 1'b0;
    prev_acc    = 1'b0;
  endtask

  localparam logic [63:0] A1 = 64'h0000_0000_0001_0000;
  localparam logic [63:0] B1 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] AX = 64'h1234_5678_9ABC_DEF0;

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          rn;
    bit          rl;
    n_checks    = 0;
    n_fail      = 0;
    exp_len_err = 1'b0;
    prev_hold   = 1'b0;
    prev_acc    = 1'b0;
    prev_diff   = '0;
    prev_last   = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a_limb      = '0;
    b_limb      = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check_val("init_in_ready", in_ready, 0);
    check_val("init_out_valid", out_valid, 0);
    check_val("init_diff_limb", diff_limb, 0);
    check_val("init_len_err", len_err, 0);
    rst = 1'b0;

    load_operand(A1, B1, 4, 1'b1, 4);
    drain(100, 100, -1, 200);

    load_operand(64'd0, 64'd1, 4, 1'b1, 4);
    load_operand(AX, AX, 4, 1'b1, 4);
    drain(100, 100, -1, 200);

    load_operand(A1, B1, 4, 1'b1, 4);
    load_operand(A1, B1, 4, 1'b1, 4);
    drain(100, 100, 3, 200);

    load_operand(64'h0000_0000_0005_0000, 64'h0000_0000_0002_0001, 2, 1'b1, 2);
    load_operand(A1, B1, 4, 1'b1, 4);
    drain(100, 100, -1, 200);
    check_val("len_err_short", len_err, 1);

    load_operand(64'd0, 64'd1, 4, 1'b0, 2);
    drain(100, 100, -1, 200);
    do_reset();
    load_operand(64'd5, 64'd3, 4, 1'b1, 4);
    drain(100, 100, -1, 200);

    for (int i = 0; i < 2000; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      rn = $urandom_range(1, 4);
      rl = (rn < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      load_operand(ra, rb, rn, rl, rn);
    end
    drain(70, 70, -1, 40000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
